// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t   : sequencer states
//   PC_STEP         : byte distance between consecutive 16-bit instructions
//   OPC_MSB/OPC_LSB : opcode field position inside an instruction word
//   HALT_OPCODE_DEF : default opcode that stops fetching
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

    localparam logic [15:0] PC_STEP         = 16'd2;
    localparam int          OPC_MSB         = 15;
    localparam int          OPC_LSB         = 12;
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hE;

    function automatic logic [3:0] opcode_of(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Presents the pc to an external instruction
// memory with one cycle of read latency, captures the returned word, and
// holds it on a valid/ready interface until accepted. Supports branch
// redirects, a halt opcode, illegal-address faulting and a saturating
// retired-instruction counter.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   start        in   pulse: begin fetching from RESET_PC (IDLE/HALT only)
//   imem_addr    out  fetch address (always equals the pc register)
//   imem_data    in   memory word, valid the cycle after imem_addr
//   instr        out  fetched instruction
//   instr_pc     out  address of instr
//   instr_valid  out  instr/instr_pc valid
//   instr_ready  in   downstream accepts instr
//   redirect     in   branch-taken pulse
//   redirect_pc  in   branch target
//   busy         out  fetching (REQ, WAIT, HOLD)
//   halted       out  in HALT
//   fault        out  illegal fetch address seen; cleared by start or reset
//   retired      out  accepted instruction count, saturating
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] PC_LIMIT    = 16'd56,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_valid;
    logic        r_fault;
    logic [15:0] r_retired;

    logic w_hs;
    logic w_illegal;
    logic w_halt_op;

    assign w_hs      = (r_state == ST_HOLD) && r_valid && instr_ready;
    assign w_illegal = (r_pc > PC_LIMIT) || r_pc[0];
    assign w_halt_op = (opcode_of(imem_data) == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Redirect outranks everything while busy, including the legality check
    // of the current pc: the check is applied to the new target next cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_REQ;
            ST_REQ: begin
                if (redirect)       w_next_state = ST_REQ;
                else if (w_illegal) w_next_state = ST_HALT;
                else                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)       w_next_state = ST_REQ;
                else if (w_halt_op) w_next_state = ST_HALT;
                else                w_next_state = ST_HOLD;
            end
            ST_HOLD: if (redirect || w_hs) w_next_state = ST_REQ;
            ST_HALT: if (start) w_next_state = ST_REQ;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_pc <= RESET_PC;
                ST_REQ: begin
                    if (redirect)       r_pc    <= redirect_pc;
                    else if (w_illegal) r_fault <= 1'b1;
                end
                ST_WAIT: begin
                    // A redirect drops the in-flight word entirely.
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else begin
                        r_instr    <= imem_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= !w_halt_op;
                    end
                end
                ST_HOLD: begin
                    // A handshake is still counted when a redirect lands
                    // in the same cycle; only the next pc differs.
                    if (w_hs && (r_retired != 16'hFFFF))
                        r_retired <= r_retired + 16'd1;
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_pc    <= r_pc + PC_STEP;
                        r_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        r_fault   <= 1'b0;
                        r_pc      <= RESET_PC;
                        r_retired <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign busy        = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_HOLD);
    assign halted      = (r_state == ST_HALT);
    assign fault       = r_fault;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program and redirect/fault scenarios
// followed by randomized traffic, all compared each cycle against a
// transaction-level reference model of the sequencer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy), .halted(halted), .fault(fault), .retired(retired)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory: 32 words covering byte addresses 0..63.
    logic [15:0] mem [0:31];

    function automatic logic [15:0] memrd(input logic [15:0] a);
        if (a < 16'd64) return mem[a[5:1]];
        return {4'h1, a[11:0]};
    endfunction

    // Reference model: mode 0=idle, 1=running, 2=halted; age counts cycles
    // since the current fetch address was issued (0 address, 1 data, 2 held).
    int          m_mode, m_age;
    logic [15:0] m_pc, m_instr, m_ipc, m_ret;
    bit          m_valid, m_fault;

    task automatic model_step();
        bit acc;
        if (!rst) begin
            m_mode = 0; m_age = 0; m_pc = 16'h0000; m_instr = 0; m_ipc = 0;
            m_valid = 0; m_fault = 0; m_ret = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_age = 0; end
        end else if (m_mode == 2) begin
            if (start) begin m_mode = 1; m_age = 0; m_fault = 0; m_pc = 0; m_ret = 0; end
        end else begin
            acc = (m_age == 2) && instr_ready;
            if (acc && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            if (redirect) begin
                m_pc = redirect_pc; m_age = 0; m_valid = 0;
            end else if (m_age == 0) begin
                if (m_pc > 16'd56 || m_pc[0]) begin m_mode = 2; m_fault = 1; end
                else m_age = 1;
            end else if (m_age == 1) begin
                m_instr = imem_data; m_ipc = m_pc;
                if (imem_data[15:12] == 4'hE) m_mode = 2;
                else begin m_age = 2; m_valid = 1; end
            end else if (acc) begin
                m_pc = m_pc + 16'd2; m_age = 0; m_valid = 0;
            end
        end
    endtask

    // One clock: inputs must already be set (after a negedge).
    task automatic tick();
        logic [15:0] pc_prev;
        pc_prev = m_pc;
        model_step();
        @(posedge clk);
        #1;
        imem_data = memrd(pc_prev);
        chk("imem_addr",   imem_addr,   m_pc);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr",       instr,       m_instr);
        chk("instr_pc",    instr_pc,    m_ipc);
        chk("busy",        busy,        m_mode == 1);
        chk("halted",      halted,      m_mode == 2);
        chk("fault",       fault,       m_fault);
        chk("retired",     retired,     m_ret);
    endtask

    task automatic drive(input bit r, input bit s, input bit rdy, input bit rd, input logic [15:0] rpc);
        @(negedge clk);
        rst = r; start = s; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
        tick();
    endtask

    initial begin
        int r;
        rst = 0; start = 0; instr_ready = 0; redirect = 0; redirect_pc = 0;
        imem_data = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'hF120; mem[1] = 16'hF121; mem[2] = 16'hEFFF;

        // Straight-line program ending in the halt opcode.
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, 0, 0);
        chk("prog_retired", retired, 16'd2);
        chk("prog_halted",  halted,  1'b1);
        chk("prog_fault",   fault,   1'b0);

        // Restart, hold off acceptance, then redirect to an out-of-range target.
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 16'h003A);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        chk("range_fault", fault, 1'b1);
        chk("range_ret",   retired, 16'd1);
        drive(1, 1, 1, 0, 0);
        chk("restart_fault", fault, 1'b0);
        drive(1, 0, 1, 1, 16'h0005);
        drive(1, 0, 1, 0, 0);
        chk("odd_fault", fault, 1'b1);

        // Randomized traffic with a fresh memory image.
        for (int i = 0; i < 32; i++)
            mem[i] = ($urandom_range(7) == 0) ? {4'hE, 12'($urandom)} : {4'($urandom_range(13)), 12'($urandom)};
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] rpc;
            r = $urandom_range(9);
            if (r < 7)       rpc = 16'($urandom_range(28) * 2);
            else if (r == 7) rpc = 16'($urandom_range(28) * 2 + 1);
            else if (r == 8) rpc = 16'd58 + 16'($urandom_range(50) * 2);
            else             rpc = 16'($urandom);
            drive($urandom_range(99) >= 2,
                  $urandom_range(9) == 0,
                  $urandom_range(9) < 7,
                  $urandom_range(11) == 0,
                  rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
